// File: rtl/softmax_bram_frontend.sv
// Host-facing buffer for the softmax core: host port A/B access while idle, and an
// in-place stream of buffer words through the engine while busy.
module softmax_bram_frontend #(
    parameter int DW     = 1028,
    parameter int AW     = 8,
    parameter int FIFO_D = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_start,
    output logic          o_busy,
    input  logic [AW-1:0] i_depth,
    input  logic          i_ext_cena,
    input  logic          i_ext_wea,
    input  logic [AW-1:0] i_ext_addra,
    input  logic [DW-1:0] i_ext_dina,
    input  logic          i_ext_cenb,
    input  logic [AW-1:0] i_ext_addrb,
    output logic [DW-1:0] o_ext_doutb,
    output logic          o_ext_conflict,
    output logic          o_eng_valid,
    output logic [DW-1:0] o_eng_data,
    output logic          o_eng_last,
    input  logic          i_eng_ready,
    input  logic          i_res_valid,
    input  logic [DW-1:0] i_res_data,
    output logic          o_res_ready
);
    localparam int PW = $clog2(FIFO_D);
    localparam int OW = PW + 2;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] fifo_mem [FIFO_D];

    logic [1:0]    state_q, state_d;
    logic [AW:0]   depth_q, depth_d, iss_q, iss_d, pop_q, pop_d, res_q, res_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          start_prev_q;
    logic          hrd_vld_p1_q, hrd_vld_p1_d, hrd_vld_p2_q, hrd_vld_p2_d;
    logic          frd_vld_p1_q, frd_vld_p1_d, frd_vld_p2_q, frd_vld_p2_d;
    logic          conflict_q, conflict_d;
    logic [DW-1:0] doutb_q, doutb_d;
    logic [DW-1:0] rd_p1_q, rd_p2_q;

    logic          idle, start_rise, issue, host_rd, host_wr, pop, push, res_acc;
    logic          rd_en, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] wr_data;
    logic [OW-1:0] occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_D - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_busy         = (state_q != S_IDLE);
    assign o_res_ready    = (state_q == S_RUN) || (state_q == S_WAIT);
    assign o_eng_valid    = (cnt_q != '0);
    assign o_eng_data     = fifo_mem[rd_ptr_q];
    assign o_eng_last     = o_eng_valid && (pop_q == depth_q - (AW+1)'(1));
    assign o_ext_doutb    = doutb_q;
    assign o_ext_conflict = conflict_q;

    // Fetch credit counts reads still in the pipe, so the FIFO can never overflow.
    always_comb begin
        idle       = (state_q == S_IDLE);
        start_rise = i_start & ~start_prev_q;
        occ        = OW'(cnt_q) + OW'(frd_vld_p1_q) + OW'(frd_vld_p2_q);
        issue      = i_en && (state_q == S_RUN) && (iss_q < depth_q) && (occ < OW'(FIFO_D));
        host_rd    = i_en & idle & i_ext_cenb;
        host_wr    = i_en & idle & i_ext_cena & i_ext_wea;
        pop        = i_en & o_eng_valid & i_eng_ready;
        res_acc    = i_en & i_res_valid & o_res_ready;
        push       = i_en & frd_vld_p2_q;
        rd_en      = host_rd | issue;
        rd_addr    = issue ? iss_q[AW-1:0] : i_ext_addrb;
        wr_en      = host_wr | res_acc;
        wr_addr    = res_acc ? res_q[AW-1:0] : i_ext_addra;
        wr_data    = res_acc ? i_res_data : i_ext_dina;
    end

    always_comb begin
        state_d      = state_q;
        depth_d      = depth_q;
        iss_d        = iss_q;
        pop_d        = pop_q;
        res_d        = res_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        hrd_vld_p1_d = hrd_vld_p1_q;
        hrd_vld_p2_d = hrd_vld_p2_q;
        frd_vld_p1_d = frd_vld_p1_q;
        frd_vld_p2_d = frd_vld_p2_q;
        conflict_d   = conflict_q;
        doutb_d      = doutb_q;
        if (i_en) begin
            hrd_vld_p1_d = host_rd;
            frd_vld_p1_d = issue;
            hrd_vld_p2_d = hrd_vld_p1_q;
            frd_vld_p2_d = frd_vld_p1_q;
            conflict_d   = ~idle & (i_ext_cena | i_ext_cenb);
            if (hrd_vld_p2_q) doutb_d = rd_p2_q;
            if (issue)   iss_d = iss_q + (AW+1)'(1);
            if (pop)     pop_d = pop_q + (AW+1)'(1);
            if (res_acc) res_d = res_q + (AW+1)'(1);
            if (push)    wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);
            cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
            case (state_q)
                S_IDLE: if (start_rise) begin
                    depth_d = {1'b0, i_depth};
                    iss_d   = '0;
                    pop_d   = '0;
                    res_d   = '0;
                    state_d = (i_depth == '0) ? S_DONE : S_RUN;
                end
                S_RUN:   if (pop && (pop_d == depth_q)) state_d = S_WAIT;
                S_WAIT:  if (res_q == depth_q) state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            depth_q      <= '0;
            iss_q        <= '0;
            pop_q        <= '0;
            res_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            start_prev_q <= 1'b0;
            hrd_vld_p1_q <= 1'b0;
            hrd_vld_p2_q <= 1'b0;
            frd_vld_p1_q <= 1'b0;
            frd_vld_p2_q <= 1'b0;
            conflict_q   <= 1'b0;
            doutb_q      <= '0;
        end else begin
            state_q      <= state_d;
            depth_q      <= depth_d;
            iss_q        <= iss_d;
            pop_q        <= pop_d;
            res_q        <= res_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            start_prev_q <= i_start;
            hrd_vld_p1_q <= hrd_vld_p1_d;
            hrd_vld_p2_q <= hrd_vld_p2_d;
            frd_vld_p1_q <= frd_vld_p1_d;
            frd_vld_p2_q <= frd_vld_p2_d;
            conflict_q   <= conflict_d;
            doutb_q      <= doutb_d;
        end
    end

    // Buffer, read pipeline and FIFO storage hold data only; reset leaves them alone.
    always_ff @(posedge i_clk) begin
        if (rd_en) rd_p1_q <= mem[rd_addr];
        if (i_en && (hrd_vld_p1_q || frd_vld_p1_q)) rd_p2_q <= rd_p1_q;
        if (wr_en) mem[wr_addr] <= wr_data;
        if (push) fifo_mem[wr_ptr_q] <= rd_p2_q;
    end
endmodule
